// File: rtl/idma_inoc_apb_cfg_master_if.sv
// Command/response stream and APB bus bundle for the iDMA inoc APB config master.
// master = the initiator block itself, slave = sequencer plus APB responder side.
interface idma_inoc_apb_cfg_master_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [2:0]        PPROT;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/idma_inoc_apb_cfg_master.sv
// APB initiator for the iDMA inoc register file: buffers register commands in a
// small FIFO, runs one APB transfer each (with timeout) and returns a response.
module idma_inoc_apb_cfg_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  idma_inoc_apb_cfg_master_if.master    bus,
  output logic                          busy,
  output logic [7:0]                    err_cnt
);
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                      mem_write_q [CMD_DEPTH];
  logic                      mem_write_d [CMD_DEPTH];
  logic [APB_ADDR_WIDTH-1:0] mem_addr_q  [CMD_DEPTH];
  logic [APB_ADDR_WIDTH-1:0] mem_addr_d  [CMD_DEPTH];
  logic [31:0]               mem_wdata_q [CMD_DEPTH];
  logic [31:0]               mem_wdata_d [CMD_DEPTH];
  logic [3:0]                mem_strb_q  [CMD_DEPTH];
  logic [3:0]                mem_strb_d  [CMD_DEPTH];
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic [3:0]                pstrb_q, pstrb_d;
  logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic                      rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic [7:0]                err_cnt_q, err_cnt_d;
  logic                      cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                      push, pop;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_strb_d    = mem_strb_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    err_cnt_d     = err_cnt_q;

    push = bus.cmd_valid && cmd_ready_q;
    // Launch when the response slot is empty or being emptied this cycle.
    pop  = (state_q == S_IDLE) && (count_q != '0) && (!rsp_valid_q || bus.rsp_ready);

    if (push) begin
      mem_write_d[wr_ptr_q] = bus.cmd_write;
      mem_addr_d[wr_ptr_q]  = bus.cmd_addr;
      mem_wdata_d[wr_ptr_q] = bus.cmd_wdata;
      mem_strb_d[wr_ptr_q]  = bus.cmd_strb;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = 32'h0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          paddr_d   = mem_addr_q[rd_ptr_q];
          pwrite_d  = mem_write_q[rd_ptr_q];
          pwdata_d  = mem_wdata_q[rd_ptr_q];
          pstrb_d   = mem_write_q[rd_ptr_q] ? mem_strb_q[rd_ptr_q] : 4'h0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'h0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          if (bus.PSLVERR && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
          state_d       = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1))) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (count_d != CNT_W'(CMD_DEPTH));
    busy_d      = (count_d != '0) || (state_d != S_IDLE) || rsp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= 32'h0;
      pstrb_q       <= 4'h0;
      wait_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      err_cnt_q     <= 8'h0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      err_cnt_q     <= err_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    mem_write_q <= mem_write_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    mem_strb_q  <= mem_strb_d;
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = 3'b000;
  assign busy            = busy_q;
  assign err_cnt         = err_cnt_q;
endmodule

// File: tb/tb_idma_inoc_apb_cfg_master.sv
// Scoreboard bench for idma_inoc_apb_cfg_master: directed commands, an APB
// responder model, and a monitor that checks each response against a queue.
module tb_idma_inoc_apb_cfg_master;
  localparam int unsigned AW = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  idma_inoc_apb_cfg_master_if #(.ADDR_W(AW)) bus ();

  idma_inoc_apb_cfg_master #(
    .APB_ADDR_WIDTH(AW), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct { logic [31:0] rdata; logic err; logic tmo; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic write; logic [31:0] wdata; logic [3:0] strb; int acc; } xfer_t;

  rsp_t  sb[$];
  xfer_t obs[$];
  int    checks = 0;
  int    errors = 0;

  bit          stuck = 1'b0;
  bit          slverr = 1'b0;
  bit          rd_ovr = 1'b0;
  logic [31:0] rd_ovr_val = 32'h0;
  int          wait_n = 0;
  int          acc = 0;
  bit          in_xfer = 1'b0;
  xfer_t       cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // APB responder: wait states, stuck mode and error injection; logs each transfer.
  always @(negedge clk) begin
    if (rst) begin
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; in_xfer = 1'b0; acc = 0;
    end else if (bus.PSEL && !bus.PENABLE) begin
      cur.addr = bus.PADDR; cur.write = bus.PWRITE; cur.wdata = bus.PWDATA;
      cur.strb = bus.PSTRB; cur.acc = 0; in_xfer = 1'b1; acc = 0;
      chk("pprot", 32'(bus.PPROT), 32'h0);
      bus.PREADY = 1'b0;
    end else if (bus.PSEL && bus.PENABLE) begin
      chk("paddr_stable", 32'(bus.PADDR), 32'(cur.addr));
      chk("pstrb_stable", 32'(bus.PSTRB), 32'(cur.strb));
      bus.PREADY  = !stuck && (acc >= wait_n);
      bus.PSLVERR = slverr && bus.PREADY;
      bus.PRDATA  = rd_ovr ? rd_ovr_val : rd_val(bus.PADDR);
      acc++;
      cur.acc = acc;
    end else begin
      if (in_xfer) obs.push_back(cur);
      in_xfer = 1'b0; acc = 0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    end
  end

  // Response monitor: every accepted response must match the queue head.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b with no response expected",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a;
    bus.cmd_wdata = d; bus.cmd_strb = s;
    while (!bus.cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got cmd_ready 0 for 500 cycles, required 1");
    end
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic er, input logic tm);
    rsp_t r;
    r.rdata = rd; r.err = er; r.tmo = tm;
    sb.push_back(r);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid || busy) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain: got %0d responses outstanding after %0d cycles, required 0", sb.size(), budget);
    end
    @(negedge clk);
  endtask

  task automatic get_xfer(output xfer_t x);
    if (obs.size() == 0) begin
      checks++; errors++;
      $display("FAIL xfer_missing: got 0 logged APB transfers, required 1");
      x.addr = '0; x.write = 1'b0; x.wdata = 32'h0; x.strb = 4'h0; x.acc = -1;
    end else x = obs.pop_front();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    xfer_t x;
    int    a2;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = 32'h0; bus.cmd_strb = 4'h0; bus.rsp_ready = 1'b0;
    bus.PRDATA = 32'h0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);

    // Write, zero wait states
    bus.rsp_ready = 1'b1;
    expect_rsp(32'h0, 1'b0, 1'b0);
    send(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF);
    drain(50);
    get_xfer(x);
    chk("t1_access_cycles", 32'(x.acc), 32'd1);
    chk("t1_pstrb", 32'(x.strb), 32'hF);
    chk("t1_paddr", 32'(x.addr), 32'h010);
    chk("t1_pwdata", x.wdata, 32'hDEAD_BEEF);
    chk("t1_pwrite", 32'(x.write), 32'h1);

    // Read with 3 wait states; strobes must be forced low
    wait_n = 3; rd_ovr = 1'b1; rd_ovr_val = 32'h1234_5678;
    expect_rsp(32'h1234_5678, 1'b0, 1'b0);
    send(1'b0, 12'h024, 32'hFFFF_FFFF, 4'hF);
    drain(50);
    get_xfer(x);
    chk("t2_access_cycles", 32'(x.acc), 32'd4);
    chk("t2_pstrb", 32'(x.strb), 32'h0);
    chk("t2_pwrite", 32'(x.write), 32'h0);
    wait_n = 0; rd_ovr = 1'b0;

    // Five reads with the response path blocked
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_rsp(rd_val(AW'(12'h100 + 4 * i)), 1'b0, 1'b0);
      send(1'b0, AW'(12'h100 + 4 * i), 32'h0, 4'h0);
    end
    repeat (6) @(negedge clk);
    chk("t3_cmd_ready_full", 32'(bus.cmd_ready), 32'h0);
    chk("t3_rsp_held", 32'(bus.rsp_valid), 32'h1);
    chk("t3_busy", 32'(busy), 32'h1);
    chk("t3_psel_idle", 32'(bus.PSEL), 32'h0);
    chk("t3_xfers_before_release", 32'(obs.size()), 32'd1);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    drain(100);
    chk("t3_xfers_total", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      get_xfer(x);
      chk("t3_order_addr", 32'(x.addr), 32'h100 + 32'(4 * i));
    end

    // Stuck responder: timeout after 8 ACCESS cycles
    stuck = 1'b1;
    expect_rsp(32'h0, 1'b1, 1'b1);
    send(1'b0, 12'h030, 32'h0, 4'h0);
    drain(100);
    get_xfer(x);
    chk("t4_access_cycles", 32'(x.acc), 32'd8);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    stuck = 1'b0;

    // Slave errors: counter saturation
    slverr = 1'b1;
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(1'b1, 12'h040, 32'hA5A5_A5A5, 4'h3);
    drain(50);
    get_xfer(x);
    chk("t5_pstrb", 32'(x.strb), 32'h3);
    chk("t5_err_cnt_2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 299; i++) begin
      expect_rsp(32'h0, 1'b1, 1'b0);
      send(1'b1, AW'(12'h040 + 4 * (i % 16)), 32'(i), 4'hF);
    end
    drain(3000);
    chk("t5_err_cnt_sat", 32'(err_cnt), 32'd255);
    obs.delete();
    slverr = 1'b0;

    // Reset during the 2nd ACCESS cycle of a stalled read
    stuck = 1'b1;
    send(1'b0, 12'h050, 32'h0, 4'h0);
    a2 = 0;
    for (int n = 0; n < 50 && a2 < 2; n++) begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE) a2++;
    end
    chk("t6_reached_access2", 32'(a2), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_psel", 32'(bus.PSEL), 32'h0);
    chk("t6_penable", 32'(bus.PENABLE), 32'h0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("t6_busy", 32'(busy), 32'h0);
    stuck = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_rsp_later", 32'(bus.rsp_valid), 32'h0);
    chk("t6_err_cnt_cleared", 32'(err_cnt), 32'h0);
    obs.delete();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
